// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition trigger controller.
//   ST_*            : FSM state encoding, also exported on the status port
//   ADDR_W_DEFAULT  : default sample-buffer address width (depth = 2^ADDR_W)
package acq_pkg;

    localparam int ADDR_W_DEFAULT = 12;

    // DONE is not a state of its own: it is ST_IDLE with the done flag set.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PREFILL   = 2'd1,
        ST_WAIT_TRIG = 2'd2,
        ST_POST      = 2'd3
    } acq_state_t;

endpackage

// File: rtl/trig_detect.sv
// Level/edge trigger detector for the decimated sample stream.
// Ports:
//   clk, rst_n  : sample-domain clock, synchronous active-low reset
//   clr         : forget the previous sample (start or cancel of a capture)
//   sample_en   : a sample is being accepted this cycle
//   data        : current sample
//   trig_level  : unsigned threshold
//   trig_rising : 1 = rising-edge trigger, 0 = falling-edge trigger
//   hit         : combinational, high only on an accepted sample that crosses
module trig_detect (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       sample_en,
    input  logic [7:0] data,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    output logic       hit
);

    logic [7:0] prev;
    logic       prev_valid;

    // NOTE: reset is synchronous, so it lives inside the clocked branch and
    // rst_n does not appear in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev       <= '0;
            prev_valid <= 1'b0;
        end else if (clr) begin
            prev_valid <= 1'b0;
        end else if (sample_en) begin
            prev       <= data;
            prev_valid <= 1'b1;
        end
    end

    // Without a valid previous sample there is no edge, so the first sample
    // after arm can never trigger even if it is already past the level.
    always_comb begin
        logic rise;
        logic fall;
        rise = (prev < trig_level) && (data >= trig_level);
        fall = (prev > trig_level) && (data <= trig_level);
        hit  = sample_en && prev_valid && (trig_rising ? rise : fall);
    end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Capture sequencer between the decimating ADC front end and the sample
// ring buffer: pre-trigger fill, trigger wait, post-trigger fill.
// Ports:
//   adc_clk, adc_rst_n     : sample clock, synchronous active-low reset
//   decim_clk, adc_data    : one-cycle sample strobe and its 8-bit sample
//   arm, abort, force_trig : control pulses
//   trig_level, trig_rising: live trigger settings
//   pretrig_len            : samples kept before the trigger, latched at arm
//   wr_en, wr_addr, wr_data: buffer write port, one cycle after the strobe
//   trig_addr              : ring address of the trigger sample
//   busy, done, state      : status
module acq_trigger_ctrl
    import acq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              adc_clk,
    input  logic              adc_rst_n,
    input  logic              decim_clk,
    input  logic [7:0]        adc_data,
    input  logic              arm,
    input  logic              abort,
    input  logic              force_trig,
    input  logic [7:0]        trig_level,
    input  logic              trig_rising,
    input  logic [ADDR_W-1:0] pretrig_len,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    acq_state_t        st, st_next;
    logic              done_next;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] pl_q;
    logic [ADDR_W-1:0] post_len;
    logic              force_pend;
    logic              arm_ok;
    logic              sample_en;
    logic              hit;
    logic              fire;

    assign arm_ok    = arm && !abort && (st == ST_IDLE);
    // A strobe caught by an abort is dropped, so nothing is written after it.
    assign sample_en = decim_clk && (st != ST_IDLE) && !abort;
    assign fire      = sample_en && (st == ST_WAIT_TRIG) && (hit || force_pend);
    // depth-1-pl is the bitwise complement of pl within ADDR_W bits.
    assign post_len  = ~pl_q;

    assign busy  = (st != ST_IDLE);
    assign state = st;

    trig_detect u_trig_detect (
        .clk         (adc_clk),
        .rst_n       (adc_rst_n),
        .clr         (arm_ok || abort),
        .sample_en   (sample_en),
        .data        (adc_data),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .hit         (hit)
    );

    // NOTE: every signal assigned here gets a default first; leaving one
    // unassigned on some path would infer a latch.
    always_comb begin
        st_next   = st;
        done_next = done;
        if (abort) begin
            st_next   = ST_IDLE;
            done_next = 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    if (arm) begin
                        done_next = 1'b0;
                        st_next   = (pretrig_len != '0) ? ST_PREFILL : ST_WAIT_TRIG;
                    end
                end
                ST_PREFILL: begin
                    if (sample_en && (cnt + ADDR_ONE == pl_q))
                        st_next = ST_WAIT_TRIG;
                end
                ST_WAIT_TRIG: begin
                    if (fire) begin
                        if (post_len == '0) begin
                            st_next   = ST_IDLE;
                            done_next = 1'b1;
                        end else begin
                            st_next = ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (sample_en && (cnt == ADDR_ONE)) begin
                        st_next   = ST_IDLE;
                        done_next = 1'b1;
                    end
                end
                default: st_next = ST_IDLE;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            st   <= ST_IDLE;
            done <= 1'b0;
        end else begin
            st   <= st_next;
            done <= done_next;
        end
    end

    always_ff @(posedge adc_clk) begin
        if (!adc_rst_n) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            trig_addr  <= '0;
            ptr        <= '0;
            cnt        <= '0;
            pl_q       <= '0;
            force_pend <= 1'b0;
        end else begin
            wr_en <= sample_en;

            if (sample_en) begin
                wr_addr <= ptr;
                wr_data <= adc_data;
                ptr     <= ptr + ADDR_ONE;
            end

            if (arm_ok) begin
                ptr  <= '0;
                cnt  <= '0;
                pl_q <= pretrig_len;
            end else if (sample_en) begin
                if (st == ST_PREFILL)
                    cnt <= cnt + ADDR_ONE;
                else if (fire)
                    cnt <= post_len;
                else if (st == ST_POST)
                    cnt <= cnt - ADDR_ONE;
            end

            if (fire)
                trig_addr <= ptr;

            // A force arriving on the trigger cycle itself stays pending;
            // it is harmless because the next arm clears it.
            if (arm_ok || abort)
                force_pend <= 1'b0;
            else if (force_trig)
                force_pend <= 1'b1;
            else if (fire)
                force_pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Directed bench for acq_trigger_ctrl with a 16-entry ring (ADDR_W=4).
// Each strobe that should be written pushes {addr,data} onto a queue; the
// write monitor pops and compares on every wr_en.
module tb_acq_trigger_ctrl;

    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          adc_clk = 1'b0;
    logic          adc_rst_n = 1'b0;
    logic          decim_clk = 1'b0;
    logic [7:0]    adc_data = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic [7:0]    trig_level = 8'h80;
    logic          trig_rising = 1'b1;
    logic [AW-1:0] pretrig_len = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] trig_addr;
    logic          busy;
    logic          done;
    logic [1:0]    state;

    int            tests = 0;
    int            fails = 0;
    wr_t           exp_q[$];
    logic [AW-1:0] mptr = '0;

    acq_trigger_ctrl #(.ADDR_W(AW)) dut (
        .adc_clk     (adc_clk),
        .adc_rst_n   (adc_rst_n),
        .decim_clk   (decim_clk),
        .adc_data    (adc_data),
        .arm         (arm),
        .abort       (abort),
        .force_trig  (force_trig),
        .trig_level  (trig_level),
        .trig_rising (trig_rising),
        .pretrig_len (pretrig_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .trig_addr   (trig_addr),
        .busy        (busy),
        .done        (done),
        .state       (state)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    // One strobe followed by two idle cycles (a sample every 3rd cycle).
    task automatic strobe(input logic [7:0] d, input bit expect_wr);
        decim_clk = 1'b1;
        adc_data  = d;
        if (expect_wr) begin
            exp_q.push_back('{addr: mptr, data: d});
            mptr = mptr + 1'b1;
        end
        tick();
        decim_clk = 1'b0;
        tick();
        tick();
    endtask

    task automatic arm_pulse(input logic [AW-1:0] pl);
        pretrig_len = pl;
        arm = 1'b1;
        tick();
        arm  = 1'b0;
        mptr = '0;
    endtask

    // Write monitor, sampling mid-cycle.
    always @(negedge adc_clk) begin
        if (wr_en === 1'b1) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_write observed=%0h expected=none", {wr_addr, wr_data});
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("write", {wr_addr, wr_data}, {e.addr, e.data});
            end
        end
    end

    initial begin
        // Reset with the strobe toggling.
        for (int i = 0; i < 3; i++) begin
            decim_clk = ~decim_clk;
            tick();
        end
        decim_clk = 1'b0;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", state, 0);
        adc_rst_n = 1'b1;
        tick();

        // Rising trigger on a ramp, pl=4: trigger at 0x80 = sample 8.
        trig_level  = 8'h80;
        trig_rising = 1'b1;
        arm_pulse(4);
        check("ramp_state_prefill", state, 1);
        check("ramp_busy", busy, 1);
        for (int i = 0; i < 4; i++) strobe(8'(i * 16), 1);
        check("ramp_state_wait", state, 2);
        for (int i = 4; i < 8; i++) strobe(8'(i * 16), 1);
        check("ramp_no_early_trig", state, 2);
        strobe(8'h80, 1);
        check("ramp_trig_addr", trig_addr, 8);
        check("ramp_state_post", state, 3);
        for (int i = 9; i < 20; i++) strobe(8'(i * 16), 1);
        check("ramp_done", done, 1);
        check("ramp_state_done", state, 0);
        check("ramp_busy_done", busy, 0);
        strobe(8'h55, 0);
        check("ramp_trig_hold", trig_addr, 8);
        check("ramp_queue_empty", exp_q.size(), 0);

        // Falling edge with wrap, re-armed from DONE, pl=2.
        // 31 samples of 0xFF, so the 0x00 lands at address 31 mod 16 = 15.
        trig_rising = 1'b0;
        arm_pulse(2);
        check("fall_done_cleared", done, 0);
        check("fall_state_prefill", state, 1);
        for (int i = 0; i < 31; i++) strobe(8'hFF, 1);
        check("fall_state_wait", state, 2);
        strobe(8'h00, 1);
        check("fall_trig_addr", trig_addr, 15);
        check("fall_state_post", state, 3);
        for (int i = 0; i < 12; i++) strobe(8'h00, 1);
        check("fall_post_not_done", done, 0);
        strobe(8'h00, 1);
        check("fall_done", done, 1);
        check("fall_queue_empty", exp_q.size(), 0);

        // Forced trigger, pl=0.
        trig_rising = 1'b1;
        arm_pulse(0);
        check("force_state_wait", state, 2);
        tick();
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        tick();
        check("force_no_strobe_yet", state, 2);
        strobe(8'h40, 1);
        check("force_trig_addr", trig_addr, 0);
        check("force_state_post", state, 3);
        for (int i = 0; i < 15; i++) strobe(8'h40, 1);
        check("force_done", done, 1);
        strobe(8'h40, 0);
        check("force_queue_empty", exp_q.size(), 0);

        // First sample after arm never triggers; arm while busy; abort in POST.
        arm_pulse(0);
        strobe(8'hF0, 1);
        check("first_no_trig", state, 2);
        strobe(8'hF0, 1);
        check("above_no_edge", state, 2);
        strobe(8'h10, 1);
        strobe(8'h90, 1);
        check("edge_trig_addr", trig_addr, 3);
        check("edge_state_post", state, 3);
        pretrig_len = 5;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy_ignored", state, 3);
        strobe(8'h22, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_state", state, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        strobe(8'h33, 0);
        check("abort_queue_empty", exp_q.size(), 0);

        // arm and abort together in IDLE: abort wins.
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_state", state, 0);
        check("arm_abort_busy", busy, 0);
        strobe(8'h44, 0);

        // Reset mid-capture.
        arm_pulse(3);
        strobe(8'h12, 1);
        strobe(8'h13, 1);
        adc_rst_n = 1'b0;
        tick();
        check("midrst_state", state, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_trig_addr", trig_addr, 0);
        check("midrst_wr_en", wr_en, 0);
        adc_rst_n = 1'b1;
        tick();
        strobe(8'h99, 0);
        check("midrst_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
